// File: rtl/axi4_wr_burst_master_if.sv
// axi4_wr_burst_master_if: AXI4 write-port bundle (AW, W, B channels)
interface axi4_wr_burst_master_if #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 32,
  parameter int IDWIDTH = 4
);
  logic [IDWIDTH-1:0] awid;
  logic [AWIDTH-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awqos;
  logic awvalid;
  logic awready;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH/8-1:0] wstrb;
  logic wlast;
  logic wvalid;
  logic wready;
  logic [IDWIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi4_wr_burst_master.sv
// axi4_wr_burst_master: splits a write command into 4 KB-safe AXI4 INCR bursts fed from a stream
module axi4_wr_burst_master #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 32,
  parameter int IDWIDTH = 4,
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic s_tvalid,
  output logic s_tready,
  axi4_wr_burst_master_if.master bus,
  output logic busy,
  output logic done,
  output logic err
);
  localparam int SZ = $clog2(DWIDTH / 8);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} state_t;
  state_t state, state_n;
  logic [AWIDTH-1:0] addr, addr_n;
  logic [15:0] rem, rem_n;
  logic [8:0] blen, blen_m1;
  logic [7:0] cnt;
  logic cmd_hs, w_hs, b_hs, last, unused;
  function automatic logic [8:0] calc(input logic [AWIDTH-1:0] a, input logic [15:0] r);
    logic [16:0] sp, m;
    sp = 17'((13'h1000 - {1'b0, a[11:0]}) >> SZ);
    m = 17'(r) < sp ? 17'(r) : sp;
    return 9'(m < 17'(MAX_BURST) ? m : 17'(MAX_BURST));
  endfunction
  assign cmd_hs = state == IDLE && cmd_valid;
  assign w_hs = bus.wvalid && bus.wready;
  assign b_hs = state == RESP && bus.bvalid;
  assign blen_m1 = blen - 9'd1;
  assign last = cnt == blen_m1[7:0];
  assign addr_n = addr + (AWIDTH'(blen) << SZ);
  assign rem_n = rem - 16'(blen);
  assign bus.awid = '0;
  assign bus.awaddr = addr;
  assign bus.awlen = blen_m1[7:0];
  assign bus.awsize = 3'(SZ);
  assign bus.awburst = 2'b01;
  assign bus.awlock = 1'b0;
  assign bus.awcache = 4'd0;
  assign bus.awprot = 3'd0;
  assign bus.awqos = 4'd0;
  assign bus.wdata = s_tdata;
  assign bus.wstrb = '1;
  assign unused = ^{bus.bid, blen_m1[8]};
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // next state and per-state handshake outputs
  always_comb begin
    state_n = state == IDLE ? (cmd_valid ? (cmd_beats == 16'd0 ? FIN : ADDR) : IDLE)
            : state == ADDR ? (bus.awready ? DATA : ADDR)
            : state == DATA ? (w_hs && last ? RESP : DATA)
            : state == RESP ? (bus.bvalid ? (rem_n == 16'd0 ? FIN : ADDR) : RESP)
            : IDLE;
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    done = state == FIN;
    bus.awvalid = state == ADDR;
    bus.wvalid = state == DATA && s_tvalid;
    s_tready = state == DATA && bus.wready;
    bus.wlast = state == DATA && last;
    bus.bready = state == RESP;
  end
  // command latch, per-burst address/remaining update and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      rem <= '0;
      blen <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr <= cmd_addr;
        rem <= cmd_beats;
        blen <= calc(cmd_addr, cmd_beats);
        err <= 1'b0;
      end
      if (b_hs) begin
        addr <= addr_n;
        rem <= rem_n;
        blen <= calc(addr_n, rem_n);
        err <= err | (bus.bresp != 2'b00);
      end
      cnt <= state != DATA ? 8'd0 : w_hs ? (last ? 8'd0 : cnt + 8'd1) : cnt;
    end
  end
endmodule

// File: tb/tb_axi4_wr_burst_master.sv
// tb_axi4_wr_burst_master: directed and random-backpressure checks of the burst write master
module tb_axi4_wr_burst_master;
  logic clk = 0, reset = 1;
  logic [31:0] cmd_addr = 0;
  logic [15:0] cmd_beats = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [63:0] s_tdata;
  logic s_tvalid, s_tready;
  logic busy, done, err;
  int checks = 0, errors = 0;
  bit rnd = 0;
  int cyc = 0;
  logic [31:0] eq_addr[$];
  int eq_len[$];
  logic [1:0] bresp_q[$];
  bit b_hs_f = 0, s_hs_f = 0, bpend = 0, aw_open = 0, wdone = 0;
  int cur_len = 0, wbeat = 0, wtotal = 0, aw_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int acc_cyc = 0, aw_cyc = 0, wfirst_cyc = 0, wlast_cyc = 0, b_cyc = 0, done_cyc = 0;
  logic [63:0] sdat = 0, wexp = 0, p_wd = 0;
  logic [31:0] p_addr = 0;
  logic [7:0] p_len = 0;
  logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wl = 0, p_done = 0, p_rst = 1;

  axi4_wr_burst_master_if #(.DWIDTH(64), .AWIDTH(32), .IDWIDTH(4)) bus();
  axi4_wr_burst_master #(.DWIDTH(64), .AWIDTH(32), .IDWIDTH(4), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [63:0] k);
    return {~k[31:0], k[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] a, input int n);
    int sp, l;
    while (n > 0) begin
      sp = (4096 - int'(a & 32'hFFF)) / 8;
      l = n < 16 ? n : 16;
      l = l < sp ? l : sp;
      eq_addr.push_back(a);
      eq_len.push_back(l);
      a += 32'(l * 8);
      n -= l;
    end
  endtask

  // slave/source driver at negedge, then observation of what the next posedge will sample
  initial begin
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    s_tvalid = 0; s_tdata = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (b_hs_f || reset) bus.bvalid = 0;
      if (s_hs_f) begin sdat++; s_tvalid = 0; end
      b_hs_f = 0; s_hs_f = 0;
      bus.awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_tvalid) s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata = pat(sdat);
      if (!bus.bvalid && bpend) bus.bvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bresp = bresp_q.size() != 0 ? bresp_q[0] : 2'b00;
      #1;
      if (reset) begin
        eq_addr.delete(); eq_len.delete();
        bpend = 0; aw_open = 0; wdone = 0; wbeat = 0;
      end else begin
        if (p_awv && !p_awr && !p_rst)
          chk("aw_hold", {bus.awvalid, bus.awlen, bus.awaddr}, {1'b1, p_len, p_addr});
        if (p_wv && !p_wr && !p_rst) chk("w_hold", {bus.wvalid, bus.wlast, bus.wdata}, {1'b1, p_wl, p_wd});
        if (p_done && !p_rst) chk("done_pulse", done, 0);
        if (s_tready) chk("s_tready_window", {aw_open, wdone}, 2'b10);
        if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
        if (bus.awvalid && bus.awready) begin
          chk("aw_burst", {bus.awaddr, bus.awlen},
              eq_addr.size() != 0 ? {24'd0, eq_addr[0], 8'(eq_len[0] - 1)} : 64'hFFFF_FFFF_FFFF_FFFF);
          cur_len = eq_len.size() != 0 ? eq_len[0] : 0;
          if (eq_addr.size() != 0) begin void'(eq_addr.pop_front()); void'(eq_len.pop_front()); end
          aw_open = 1; wdone = 0; wbeat = 0; aw_cnt++; aw_cyc = cyc;
        end
        if (bus.wvalid && bus.wready) begin
          chk("w_after_aw", {aw_open, wdone}, 2'b10);
          chk("w_data", bus.wdata, pat(wexp));
          chk("w_last", bus.wlast, wbeat == cur_len - 1);
          if (wbeat == 0) wfirst_cyc = cyc;
          wexp++; wtotal++; wbeat++;
          if (bus.wlast) begin wdone = 1; bpend = 1; wlast_cyc = cyc; end
        end
        if (s_tvalid && s_tready) s_hs_f = 1;
        if (bus.bvalid && bus.bready) begin
          b_hs_f = 1; bpend = 0; aw_open = 0; b_cyc = cyc;
          if (bresp_q.size() != 0) void'(bresp_q.pop_front());
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
      end
      p_awv = bus.awvalid; p_awr = bus.awready; p_addr = bus.awaddr; p_len = bus.awlen;
      p_wv = bus.wvalid; p_wr = bus.wready; p_wd = bus.wdata; p_wl = bus.wlast;
      p_done = done; p_rst = reset;
    end
  end

  task automatic run_cmd(input logic [31:0] a, input int n, input logic e);
    int d0, w0, c0;
    d0 = done_cnt; w0 = wtotal; c0 = acc_cnt;
    @(negedge clk);
    cmd_addr = a; cmd_beats = 16'(n); cmd_valid = 1;
    #2;
    for (int t = 0; t < 20 && acc_cnt == c0; t++) begin @(negedge clk); #2; end
    chk("accept", acc_cnt - c0, 1);
    @(negedge clk);
    cmd_valid = 0;
    #2;
    chk("err_clear", err, 0);
    chk("aw_start", bus.awvalid, n != 0);
    for (int t = 0; t < 4000 && done_cnt == d0; t++) begin @(negedge clk); #2; end
    chk("done_seen", done_cnt - d0, 1);
    chk("err_at_done", err, e);
    chk("beats", wtotal - w0, n);
    chk("bursts_left", eq_addr.size(), 0);
    @(negedge clk);
    #2;
    chk("single_done", done_cnt - d0, 1);
    chk("idle_after", {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    int a0, w0;
    logic [31:0] ra;
    int rn;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, s_tready, bus.bready, bus.wlast}, 0);
    chk("const_aw", {bus.awid, bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.awqos},
        {4'd0, 3'd3, 2'b01, 12'd0});
    chk("const_wstrb", bus.wstrb, 8'hFF);
    @(negedge clk);
    reset = 0;
    eq_addr.push_back(32'h1000); eq_len.push_back(16);
    run_cmd(32'h1000, 16, 0);
    chk("t1_aw_cyc", aw_cyc, acc_cyc + 1);
    chk("t1_wfirst", wfirst_cyc, acc_cyc + 2);
    chk("t1_wlast", wlast_cyc, acc_cyc + 17);
    chk("t1_b", b_cyc, wlast_cyc + 1);
    chk("t1_done", done_cyc, acc_cyc + 19);
    a0 = aw_cnt;
    eq_addr.push_back(32'h000); eq_len.push_back(16);
    eq_addr.push_back(32'h080); eq_len.push_back(16);
    eq_addr.push_back(32'h100); eq_len.push_back(8);
    run_cmd(32'h0, 40, 0);
    chk("t2_aw_count", aw_cnt - a0, 3);
    a0 = aw_cnt;
    eq_addr.push_back(32'hFC0); eq_len.push_back(8);
    eq_addr.push_back(32'h1000); eq_len.push_back(8);
    run_cmd(32'hFC0, 16, 0);
    chk("t3_aw_count", aw_cnt - a0, 2);
    a0 = aw_cnt;
    bresp_q.push_back(2'b10);
    eq_addr.push_back(32'h000); eq_len.push_back(16);
    eq_addr.push_back(32'h080); eq_len.push_back(4);
    run_cmd(32'h0, 20, 1);
    chk("err_aw_count", aw_cnt - a0, 2);
    a0 = aw_cnt;
    run_cmd(32'h40, 0, 0);
    chk("zero_done_lat", done_cyc, acc_cyc + 1);
    chk("zero_no_aw", aw_cnt - a0, 0);
    eq_addr.push_back(32'h0); eq_len.push_back(16);
    @(negedge clk);
    cmd_addr = 0; cmd_beats = 16; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    w0 = wtotal;
    #2;
    for (int t = 0; t < 100 && wtotal - w0 < 5; t++) begin @(negedge clk); #2; end
    chk("rst_mid_beats", wtotal - w0, 5);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    #2;
    chk("rst_mid_state", {bus.wvalid, busy, cmd_ready, bus.awvalid, s_tready}, 5'b00100);
    @(negedge clk);
    reset = 0;
    eq_addr.push_back(32'h2000); eq_len.push_back(4);
    run_cmd(32'h2000, 4, 0);
    rnd = 1;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom & 32'h0000_7FF8;
      rn = $urandom_range(0, 40);
      model_push(ra, rn);
      run_cmd(ra, rn, 0);
    end
    rnd = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
